cmd_parser: RTL

CMD_PARSER -- requirements
Module: cmd_parser

---
 rtl/cmd_parser.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_parser.sv
// cmd_parser: byte-stream command decoder.
// Short commands (opc[7]=0) decode in one byte. Long commands (opc[7]=1)
// take four payload bytes, which are assembled LSB-first into data_o.
// Stage opcodes 0xC0-0xDF also carry a stage index and a mask/val/cfg type.
// Optional feature: define CMD_PARSER_TIMEOUT_EN to abort a long command
// after TIMEOUT_CYC idle cycles inside DATA. Without it, DATA waits forever.
module cmd_parser #(
    parameter int STAGES      = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int STG_W      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             stb_i,
    input  logic [7:0]       opc_i,
    output logic [8:0]       short_o,
    output logic [7:0]       long_o,
    output logic [STG_W-1:0] stg_o,
    output logic [31:0]      data_o,
    output logic             stb_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam logic [3:0] STAGES_L = 4'(STAGES);

    // Reject illegal parameter values at elaboration time.
    if (!(STAGES == 2 || STAGES == 4 || STAGES == 8)) begin : g_bad_stages
        $error("cmd_parser: STAGES must be 2, 4 or 8");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("cmd_parser: TIMEOUT_CYC must be in 2..65535");
    end

    state_e             state_q, state_d;
    logic [7:0]         opc_q, opc_d;     // latched long opcode
    logic [1:0]         cnt_q, cnt_d;     // payload bytes received so far
    logic [23:0]        buf_q, buf_d;     // first three payload bytes
    logic [8:0]         short_q, short_d;
    logic [7:0]         long_q, long_d;
    logic [STG_W-1:0]   stg_q, stg_d;
    logic [31:0]        data_q, data_d;
    logic               stb_q, stb_d;
    logic               err_q, err_d;

    // Decoded views of the incoming byte and of the latched long opcode.
    logic [8:0]         short_hit;
    logic [7:0]         long_hit;
    logic [2:0]         long_stage;
    logic               long_ok;

`ifdef CMD_PARSER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]        tmo_q, tmo_d;     // idle cycles seen in DATA
`endif

    // Short opcode lookup: one-hot index, all zero for an unknown opcode.
    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        short_hit = '0;
        case (opc_i)
            8'h00:   short_hit[0] = 1'b1;
            8'h01:   short_hit[1] = 1'b1;
            8'h02:   short_hit[2] = 1'b1;
            8'h04:   short_hit[3] = 1'b1;
            8'h05:   short_hit[4] = 1'b1;
            8'h06:   short_hit[5] = 1'b1;
            8'h0F:   short_hit[6] = 1'b1;
            8'h11:   short_hit[7] = 1'b1;
            8'h13:   short_hit[8] = 1'b1;
            default: short_hit = '0;
        endcase
    end

    // Long opcode lookup: command bit, stage index and legality check.
    always_comb begin
        long_hit   = '0;
        long_stage = '0;
        case (opc_q)
            8'h80:   long_hit[3] = 1'b1;
            8'h81:   long_hit[4] = 1'b1;
            8'h82:   long_hit[5] = 1'b1;
            8'h9E:   long_hit[6] = 1'b1;
            8'h9F:   long_hit[7] = 1'b1;
            default: begin
                // 0xC0-0xCF -> stages 0..3, 0xD0-0xDF -> stages 4..7.
                if (opc_q[7:5] == 3'b110) begin
                    long_stage = {opc_q[4], opc_q[3:2]};
                    case (opc_q[1:0])
                        2'd0:    long_hit[0] = 1'b1;
                        2'd1:    long_hit[1] = 1'b1;
                        2'd2:    long_hit[2] = 1'b1;
                        default: long_hit = '0;
                    endcase
                end
            end
        endcase
        long_ok = (long_hit != '0) && ({1'b0, long_stage} < STAGES_L);
    end

    // Next-state and next-output logic for the IDLE/DATA collector.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        short_d = '0;
        long_d  = '0;
        stg_d   = stg_q;
        data_d  = data_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (stb_i) begin
                    if (!opc_i[7]) begin
                        if (short_hit != '0) begin
                            short_d = short_hit;
                            stb_d   = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        opc_d   = opc_i;
                        cnt_d   = '0;
                        state_d = DATA;
`ifdef CMD_PARSER_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            DATA: begin
                if (stb_i) begin
`ifdef CMD_PARSER_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (long_ok) begin
                            long_d = long_hit;
                            stb_d  = 1'b1;
                            data_d = {opc_i, buf_q};
                            stg_d  = long_stage[STG_W-1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        case (cnt_q)
                            2'd0:    buf_d[7:0]   = opc_i;
                            2'd1:    buf_d[15:8]  = opc_i;
                            default: buf_d[23:16] = opc_i;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
`ifdef CMD_PARSER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared by the asynchronous reset.
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            opc_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            short_q <= '0;
            long_q  <= '0;
            stg_q   <= '0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            short_q <= short_d;
            long_q  <= long_d;
            stg_q   <= stg_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

`ifdef CMD_PARSER_TIMEOUT_EN
    // Idle-cycle counter for aborting a stalled long command.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign short_o = short_q;
    assign long_o  = long_q;
    assign stg_o   = stg_q;
    assign data_o  = data_q;
    assign stb_o   = stb_q;
    assign err_o   = err_q;
    assign busy_o  = (state_q == DATA);

endmodule
